inst_mem_loadable: RTL and testbench

INST_MEM_LOADABLE -- requirements
Module: inst_mem_loadable

---
 rtl/inst_mem_loadable.sv | 162 ++++++++++++++++
 tb/tb_inst_mem_loadable.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory with a byte-addressed registered fetch port.
//
// The block runs in one of three modes:
//   IDLE - after reset; waits for load_en (go load) or start (go run)
//   LOAD - accepts one word per cycle on load_valid/load_addr/load_data
//   RUN  - serves fetches; Instruction/inst_valid/fault update one edge
//          after a fetch_req, or hold while stall is high
//
// Ports:
//   clk, reset            sole clock; asynchronous active-high reset
//   load_en, start        mode requests
//   load_valid/addr/data  load write channel; load_ready is high in LOAD
//   fetch_req, stall      fetch request and output hold
//   Address               byte address of the fetch (word index in [ADDR_W+1:2])
//   Instruction           registered fetched word (NOP_WORD on fault/no fetch)
//   inst_valid, fault     fetch completed / 00 ok, 01 misaligned, 10 out of range
//   loaded_words          accepted load writes since entering LOAD (saturating)
//   mode                  00 IDLE, 01 LOAD, 10 RUN
//
// Memory contents have no reset and survive both reset and mode changes.
module inst_mem_loadable #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic              start,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              fetch_req,
    input  logic              stall,
    input  logic [31:0]       Address,
    output logic [DATA_W-1:0] Instruction,
    output logic              inst_valid,
    output logic [1:0]        fault,
    output logic [ADDR_W:0]   loaded_words,
    output logic [1:0]        mode
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10
    } state_t;

    localparam int unsigned   DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [1:0]    FLT_OK    = 2'b00;
    localparam logic [1:0]    FLT_ALIGN = 2'b01;
    localparam logic [1:0]    FLT_RANGE = 2'b10;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     loaded_q, loaded_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                valid_q, valid_d;
    logic [1:0]          fault_q, fault_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   fetch_idx;
    logic                misaligned;
    logic                out_of_range;

    assign fetch_idx    = Address[ADDR_W+1:2];
    assign misaligned   = |Address[1:0];
    assign out_of_range = |(Address >> (ADDR_W + 2));
    assign mem_we       = (state_q == S_LOAD) && load_valid;

    // Next mode, in priority order.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (load_en)    state_d = S_LOAD;
                else if (start) state_d = S_RUN;
            end
            S_LOAD: begin
                if (!load_en)   state_d = S_RUN;
            end
            S_RUN: begin
                if (load_en)    state_d = S_LOAD;
            end
            default:            state_d = S_IDLE;
        endcase
    end

    // Load counter: cleared on entry into LOAD, counts accepted writes.
    always_comb begin
        loaded_d = loaded_q;
        if (mem_we && (loaded_q != WORDS_MAX)) begin
            loaded_d = loaded_q + (ADDR_W+1)'(1);
        end
        if ((state_d == S_LOAD) && (state_q != S_LOAD)) begin
            loaded_d = '0;
        end
    end

    // Fetch output register. Leaving RUN for LOAD drops any pending result
    // even under stall, so the abort takes priority over the stall hold.
    always_comb begin
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        if ((state_q != S_RUN) || (state_d == S_LOAD)) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            fault_d = FLT_OK;
        end else if (!stall) begin
            if (!fetch_req) begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                fault_d = FLT_OK;
            end else if (misaligned) begin
                instr_d = NOP_WORD;
                valid_d = 1'b1;
                fault_d = FLT_ALIGN;
            end else if (out_of_range) begin
                instr_d = NOP_WORD;
                valid_d = 1'b1;
                fault_d = FLT_RANGE;
            end else begin
                instr_d = mem[fetch_idx];
                valid_d = 1'b1;
                fault_d = FLT_OK;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            loaded_q <= '0;
            instr_q  <= NOP_WORD;
            valid_q  <= 1'b0;
            fault_q  <= FLT_OK;
        end else begin
            state_q  <= state_d;
            loaded_q <= loaded_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr] <= load_data;
        end
    end

    assign load_ready   = (state_q == S_LOAD);
    assign mode         = state_q;
    assign Instruction  = instr_q;
    assign inst_valid   = valid_q;
    assign fault        = fault_q;
    assign loaded_words = loaded_q;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Self-checking bench for inst_mem_loadable (ADDR_W=8, DATA_W=32).
// A behavioural model advances on every rising edge from the inputs applied
// for that cycle; all outputs are compared on the falling edge.
module tb_inst_mem_loadable;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h00000000;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en, start, load_valid;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          fetch_req, stall;
    logic [31:0]   Address;
    logic [DW-1:0] Instruction;
    logic          inst_valid;
    logic [1:0]    fault;
    logic [AW:0]   loaded_words;
    logic [1:0]    mode;

    inst_mem_loadable #(.ADDR_W(AW), .DATA_W(DW), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .start(start),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready), .fetch_req(fetch_req), .stall(stall),
        .Address(Address), .Instruction(Instruction), .inst_valid(inst_valid),
        .fault(fault), .loaded_words(loaded_words), .mode(mode)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: 0 IDLE, 1 LOAD, 2 RUN.
    logic [31:0] mmem  [DEPTH];
    bit          known [DEPTH];
    int          m_mode;
    int          m_lw;
    logic [31:0] m_instr;
    bit          m_iv;
    int          m_fault;
    bit          m_known;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_lw    = 0;
        m_instr = NOP;
        m_iv    = 0;
        m_fault = 0;
        m_known = 1;
    endtask

    task automatic model_update();
        int prev, nxt;
        int idx;
        if (reset) begin
            model_reset();
            return;
        end
        prev = m_mode;
        if (load_en)                nxt = 1;
        else if (prev == 0)         nxt = start ? 2 : 0;
        else                        nxt = 2;
        if (prev == 1 && load_valid) begin
            mmem[load_addr]  = load_data;
            known[load_addr] = 1;
            if (m_lw < DEPTH) m_lw = m_lw + 1;
        end
        if (nxt == 1 && prev != 1) m_lw = 0;
        if (prev == 2 && nxt == 2 && stall) begin
            // outputs hold
        end else if (prev == 2 && nxt == 2 && fetch_req) begin
            m_iv = 1;
            if (Address % 4 != 0) begin
                m_instr = NOP; m_fault = 1; m_known = 1;
            end else if (Address >= 4 * DEPTH) begin
                m_instr = NOP; m_fault = 2; m_known = 1;
            end else begin
                idx     = int'(Address / 4);
                m_instr = mmem[idx];
                m_known = known[idx];
                m_fault = 0;
            end
        end else begin
            m_instr = NOP; m_iv = 0; m_fault = 0; m_known = 1;
        end
        m_mode = nxt;
    endtask

    task automatic compare_all();
        chk("mode",         64'(mode),         64'(m_mode));
        chk("loaded_words", 64'(loaded_words), 64'(m_lw));
        chk("load_ready",   64'(load_ready),   64'(m_mode == 1));
        chk("inst_valid",   64'(inst_valid),   64'(m_iv));
        chk("fault",        64'(fault),        64'(m_fault));
        if (m_known) chk("instruction", 64'(Instruction), 64'(m_instr));
    endtask

    // One clock: model advances at the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        load_en = 0; start = 0; load_valid = 0; load_addr = '0; load_data = '0;
        fetch_req = 0; stall = 0; Address = '0;
    endtask

    logic [31:0] prog [3];
    bit          le_sticky;
    int          r;

    initial begin
        prog[0] = 32'h08000003; prog[1] = 32'h0000d820; prog[2] = 32'h3c103000;
        for (int i = 0; i < DEPTH; i++) known[i] = 0;
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        cycle();
        cycle();
        reset = 1'b0;
        chk("rst_mode_lit", 64'(mode), 64'd0);
        chk("rst_ready_lit", 64'(load_ready), 64'd0);

        // Load three words, then fetch byte address 0x4.
        load_en = 1;
        cycle();
        for (int i = 0; i < 3; i++) begin
            load_valid = 1; load_addr = AW'(i); load_data = prog[i];
            cycle();
        end
        load_valid = 0; load_en = 0;
        cycle();
        chk("load_count_lit", 64'(loaded_words), 64'd3);
        chk("run_mode_lit", 64'(mode), 64'd2);
        fetch_req = 1; Address = 32'h4;
        cycle();
        chk("fetch4_lit", 64'(Instruction), 64'h0000d820);
        chk("fetch4_valid_lit", 64'(inst_valid), 64'd1);

        // Misaligned, then out-of-range.
        Address = 32'h6;
        cycle();
        chk("misalign_fault_lit", 64'(fault), 64'd1);
        chk("misalign_instr_lit", 64'(Instruction), 64'h0);
        Address = 32'h400;
        cycle();
        chk("range_fault_lit", 64'(fault), 64'd2);

        // Top word: load mem[255], then fetch 0x3FC.
        fetch_req = 0; load_en = 1;
        cycle();
        load_valid = 1; load_addr = 8'hFF; load_data = 32'hdeadbeef;
        cycle();
        load_valid = 0; load_en = 0;
        cycle();
        fetch_req = 1; Address = 32'h3FC;
        cycle();
        chk("top_word_lit", 64'(Instruction), 64'hdeadbeef);
        chk("top_fault_lit", 64'(fault), 64'd0);

        // Stall hold.
        Address = 32'h0;
        cycle();
        stall = 1; Address = 32'h8;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_hold_lit", 64'(Instruction), 64'h08000003);
        end
        stall = 0;
        cycle();
        chk("after_stall_lit", 64'(Instruction), 64'h3c103000);

        // Reset in the middle of a load.
        fetch_req = 0; load_en = 1;
        cycle();
        for (int i = 0; i < 2; i++) begin
            load_valid = 1; load_addr = AW'(i + 3); load_data = 32'h11110000 + i;
            cycle();
        end
        assert_reset();
        chk("midload_lw_lit", 64'(loaded_words), 64'd0);
        chk("midload_mode_lit", 64'(mode), 64'd0);
        cycle();
        reset = 0; load_en = 0; load_valid = 0; start = 1;
        cycle();
        chk("start_run_lit", 64'(mode), 64'd2);
        start = 0; fetch_req = 1; Address = 32'h0;
        cycle();
        chk("post_reset_fetch_lit", 64'(Instruction), 64'h08000003);

        // Reload abort while stalled with a valid result.
        stall = 1;
        cycle();
        load_en = 1;
        cycle();
        chk("abort_mode_lit", 64'(mode), 64'd1);
        chk("abort_valid_lit", 64'(inst_valid), 64'd0);
        chk("abort_lw_lit", 64'(loaded_words), 64'd0);
        chk("abort_ready_lit", 64'(load_ready), 64'd1);

        // Fill the whole memory and overrun the counter to check saturation.
        stall = 0; fetch_req = 0;
        for (int i = 0; i < DEPTH + 10; i++) begin
            load_valid = 1; load_addr = AW'(i); load_data = $urandom;
            cycle();
        end
        chk("saturate_lit", 64'(loaded_words), 64'd256);
        load_valid = 0; load_en = 0;
        cycle();

        // Randomized traffic.
        le_sticky = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) le_sticky = ~le_sticky;
            load_en    = le_sticky;
            start      = ($urandom_range(0, 3) == 0);
            load_valid = $urandom_range(0, 1);
            load_addr  = AW'($urandom);
            load_data  = $urandom;
            fetch_req  = ($urandom_range(0, 9) < 7);
            stall      = ($urandom_range(0, 4) == 0);
            r = int'($urandom_range(0, 3));
            case (r)
                0:       Address = $urandom | 32'h1;
                1:       Address = ($urandom | 32'h400) & ~32'h3;
                default: Address = {22'b0, 8'($urandom), 2'b00};
            endcase
            if (reset) reset = 0;
            else if ($urandom_range(0, 99) == 0) assert_reset();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
